// File: rtl/axi_mmio_target_if.sv
// AXI4 bus bundle for the MMIO target window: AW, W, B, AR and R channels
// with master/slave modports. Data width is fixed at 64 bits.
interface axi_mmio_target_if #(
  parameter int ADDR_WIDTH = 31,
  parameter int ID_WIDTH   = 5
);
  logic                  awvalid, awready;
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic [3:0]            awqos;

  logic                  wvalid, wready;
  logic [63:0]           wdata;
  logic [7:0]            wstrb;
  logic                  wlast;

  logic                  bvalid, bready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;

  logic                  arvalid, arready;
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;

  logic                  rvalid, rready;
  logic [ID_WIDTH-1:0]   rid;
  logic [63:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
    output arready,
    output rvalid, rid, rdata, rresp, rlast,
    input  rready
  );
endinterface

// File: rtl/axi_mmio_target.sv
// AXI4 slave backed by a DEPTH x 64-bit flop array; FIXED/INCR bursts, one
// outstanding transaction per direction. Define AXI_MMIO_TARGET_DECERR_EN for window range checking.
module axi_mmio_target #(
  parameter int ADDR_WIDTH = 31,
  parameter int ID_WIDTH   = 5,
  parameter int DEPTH      = 512,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(32'h6000_0000)
) (
  input  logic clk,
  input  logic reset,
  axi_mmio_target_if.slave s_axi
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic addr_t next_addr(addr_t addr, logic [2:0] size, logic [1:0] burst);
    addr_t step;
    step = addr_t'(1) << size;
    if (burst == BURST_INCR) return (addr & ~(step - addr_t'(1))) + step;
    return addr;
  endfunction

  // BASE_ADDR is aligned to the window size, so the word index is just the
  // low offset bits.
  function automatic logic [IDX_W-1:0] word_idx(addr_t addr);
    return addr[IDX_W+2:3] - BASE_ADDR[IDX_W+2:3];
  endfunction

  function automatic logic burst_bad(logic [1:0] burst, logic [2:0] size);
    return (burst != BURST_FIXED && burst != BURST_INCR) || (size > 3'd3);
  endfunction

  function automatic logic [1:0] worst(logic [1:0] a, logic [1:0] b);
    if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
    if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  logic [63:0] mem [DEPTH];

  // ---------------- write channel ----------------
  w_state_t       w_state, w_next;
  addr_t          w_addr;
  logic [7:0]     w_len;
  logic [2:0]     w_size;
  logic [1:0]     w_burst;
  logic           w_bad, w_oor;
  logic [8:0]     w_beat;
  logic           aw_fire, w_fire, w_over, wlast_err, w_commit;
  logic [1:0]     w_beat_resp, w_err;

`ifdef AXI_MMIO_TARGET_DECERR_EN
  assign w_oor = (w_addr - BASE_ADDR) >= addr_t'(DEPTH * 8);
`else
  assign w_oor = 1'b0;
`endif

  assign aw_fire     = s_axi.awvalid && s_axi.awready;
  assign w_fire      = s_axi.wvalid && (w_state == W_DATA);
  assign w_over      = w_beat > {1'b0, w_len};
  assign wlast_err   = s_axi.wlast ? (w_beat != {1'b0, w_len}) : (w_beat == {1'b0, w_len});
  assign w_beat_resp = w_bad ? RESP_SLVERR : (w_oor ? RESP_DECERR : RESP_OKAY);
  assign w_err       = worst(w_over ? RESP_OKAY : w_beat_resp, wlast_err ? RESP_SLVERR : RESP_OKAY);
  assign w_commit    = w_fire && !w_over && (w_beat_resp == RESP_OKAY);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_next       = w_state;
    s_axi.wready = 1'b0;
    s_axi.bvalid = 1'b0;
    case (w_state)
      W_IDLE: if (aw_fire) w_next = W_DATA;
      W_DATA: begin
        s_axi.wready = 1'b1;
        if (s_axi.wvalid && s_axi.wlast) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state       <= W_IDLE;
      s_axi.awready <= 1'b0;
      s_axi.bid     <= '0;
      s_axi.bresp   <= RESP_OKAY;
      w_addr        <= '0;
      w_len         <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_bad         <= 1'b0;
      w_beat        <= '0;
    end else begin
      w_state       <= w_next;
      s_axi.awready <= (w_next == W_IDLE);
      if (aw_fire) begin
        s_axi.bid   <= s_axi.awid;
        s_axi.bresp <= RESP_OKAY;
        w_addr      <= s_axi.awaddr;
        w_len       <= s_axi.awlen;
        w_size      <= s_axi.awsize;
        w_burst     <= s_axi.awburst;
        w_bad       <= burst_bad(s_axi.awburst, s_axi.awsize);
        w_beat      <= '0;
      end
      if (w_fire) begin
        w_addr      <= next_addr(w_addr, w_size, w_burst);
        s_axi.bresp <= worst(s_axi.bresp, w_err);
        if (!w_beat[8]) w_beat <= w_beat + 9'd1;
      end
    end
  end

  // NOTE: the storage array has no reset; its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 8; b++)
        if (s_axi.wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= s_axi.wdata[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------
  r_state_t       r_state, r_next;
  addr_t          r_addr, r_load_addr;
  logic [7:0]     r_len, r_beat;
  logic [2:0]     r_size;
  logic [1:0]     r_burst, r_load_resp;
  logic           r_bad, r_load_bad, r_oor, ar_fire, r_fire;
  logic [63:0]    r_load_data;

  // The beat being launched: the AR address when idle, else the next address.
  assign r_load_addr = (r_state == R_IDLE) ? s_axi.araddr : next_addr(r_addr, r_size, r_burst);
  assign r_load_bad  = (r_state == R_IDLE) ? burst_bad(s_axi.arburst, s_axi.arsize) : r_bad;

`ifdef AXI_MMIO_TARGET_DECERR_EN
  assign r_oor = (r_load_addr - BASE_ADDR) >= addr_t'(DEPTH * 8);
`else
  assign r_oor = 1'b0;
`endif

  assign r_load_resp = r_load_bad ? RESP_SLVERR : (r_oor ? RESP_DECERR : RESP_OKAY);
  assign r_load_data = (r_load_resp == RESP_OKAY) ? mem[word_idx(r_load_addr)] : 64'h0;
  assign ar_fire     = s_axi.arvalid && s_axi.arready;
  assign r_fire      = s_axi.rready && (r_state == R_DATA);

  always_comb begin
    r_next       = r_state;
    s_axi.rvalid = 1'b0;
    s_axi.rlast  = 1'b0;
    case (r_state)
      R_IDLE: if (ar_fire) r_next = R_DATA;
      R_DATA: begin
        s_axi.rvalid = 1'b1;
        s_axi.rlast  = (r_beat == r_len);
        if (s_axi.rready && r_beat == r_len) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= R_IDLE;
      s_axi.arready <= 1'b0;
      s_axi.rid     <= '0;
      s_axi.rdata   <= '0;
      s_axi.rresp   <= RESP_OKAY;
      r_addr        <= '0;
      r_len         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_bad         <= 1'b0;
      r_beat        <= '0;
    end else begin
      r_state       <= r_next;
      s_axi.arready <= (r_next == R_IDLE);
      if (ar_fire) begin
        s_axi.rid   <= s_axi.arid;
        s_axi.rdata <= r_load_data;
        s_axi.rresp <= r_load_resp;
        r_addr      <= s_axi.araddr;
        r_len       <= s_axi.arlen;
        r_size      <= s_axi.arsize;
        r_burst     <= s_axi.arburst;
        r_bad       <= r_load_bad;
        r_beat      <= '0;
      end else if (r_fire && r_beat != r_len) begin
        s_axi.rdata <= r_load_data;
        s_axi.rresp <= r_load_resp;
        r_addr      <= r_load_addr;
        r_beat      <= r_beat + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_axi_mmio_target.sv
// Directed bench for axi_mmio_target: a word-array model predicts every B and
// R beat, and a negedge compare process checks them; literals pin key results.
module tb_axi_mmio_target;
  localparam int AW = 31;
  localparam int IW = 5;
  localparam int DEPTH = 512;
  localparam logic [30:0] BASE  = 31'h6000_0000;
  localparam logic [30:0] ALIAS = 31'h6000_1000;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0] FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2;

  typedef struct {
    logic [4:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;
  typedef struct {
    logic [4:0] id;
    logic [1:0] resp;
  } b_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axi_mmio_target_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();
  axi_mmio_target #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .s_axi(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  r_exp_t exp_r[$];
  b_exp_t exp_b[$];
  logic [63:0] cap_rdata[$];
  logic [1:0]  cap_rresp[$];
  logic        cap_rlast[$];
  logic [1:0]  cap_bresp[$];

  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic [63:0] mdl_mem [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: no handshake within cycle budget", name);
  endtask

  // ---------------- model ----------------
  function automatic longint unsigned mdl_off(logic [30:0] a);
    return (longint'(a) + 64'h8000_0000 - longint'(BASE)) % 64'h8000_0000;
  endfunction

  function automatic int mdl_idx(logic [30:0] a);
    return int'((mdl_off(a) / 8) % DEPTH);
  endfunction

  function automatic bit mdl_oor(logic [30:0] a);
`ifdef AXI_MMIO_TARGET_DECERR_EN
    return mdl_off(a) >= longint'(DEPTH * 8);
`else
    return (a === 31'bx);
`endif
  endfunction

  function automatic logic [30:0] mdl_step(logic [30:0] a, logic [2:0] size, logic [1:0] burst);
    longint unsigned unit;
    longint unsigned la;
    if (burst != INCR) return a;
    unit = longint'(1) << size;
    la = longint'(a);
    return 31'((la / unit) * unit + unit);
  endfunction

  task automatic model_write(input logic [30:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [4:0] id, input int last_at);
    bit bad;
    bit any_slv;
    bit any_dec;
    logic [30:0] a;
    b_exp_t e;
    bad = (burst > INCR) || (size > 3);
    any_slv = bad || (last_at != int'(len));
    any_dec = 0;
    a = addr;
    for (int i = 0; i <= last_at; i++) begin
      if (i <= int'(len) && !bad) begin
        if (mdl_oor(a)) any_dec = 1;
        else for (int b = 0; b < 8; b++)
          if (ws[i][b]) mdl_mem[mdl_idx(a)][8*b +: 8] = wd[i][8*b +: 8];
      end
      a = mdl_step(a, size, burst);
    end
    e.id = id;
    e.resp = any_slv ? SLVERR : (any_dec ? DECERR : OKAY);
    exp_b.push_back(e);
  endtask

  task automatic model_read(input logic [30:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [4:0] id);
    bit bad;
    logic [30:0] a;
    bad = (burst > INCR) || (size > 3);
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      r_exp_t e;
      e.id = id;
      e.last = (i == int'(len));
      if (bad) begin
        e.data = 64'h0; e.resp = SLVERR;
      end else if (mdl_oor(a)) begin
        e.data = 64'h0; e.resp = DECERR;
      end else begin
        e.data = mdl_mem[mdl_idx(a)]; e.resp = OKAY;
      end
      exp_r.push_back(e);
      a = mdl_step(a, size, burst);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rvalid) begin
        if (exp_r.size() == 0) timeout("r_unexpected_beat");
        else begin
          check("rdata", bus.rdata, exp_r[0].data);
          check("rresp", 64'(bus.rresp), 64'(exp_r[0].resp));
          check("rlast", 64'(bus.rlast), 64'(exp_r[0].last));
          check("rid",   64'(bus.rid),   64'(exp_r[0].id));
        end
        if (bus.rready) begin
          cap_rdata.push_back(bus.rdata);
          cap_rresp.push_back(bus.rresp);
          cap_rlast.push_back(bus.rlast);
          if (exp_r.size() > 0) void'(exp_r.pop_front());
        end
      end
      if (bus.bvalid) begin
        if (exp_b.size() == 0) timeout("b_unexpected_resp");
        else begin
          check("bresp", 64'(bus.bresp), 64'(exp_b[0].resp));
          check("bid",   64'(bus.bid),   64'(exp_b[0].id));
        end
        if (bus.bready) begin
          cap_bresp.push_back(bus.bresp);
          if (exp_b.size() > 0) void'(exp_b.pop_front());
        end
      end
    end
  end

  // ---------------- bus tasks ----------------
  function automatic logic sig(input int sel);
    case (sel)
      0: return bus.awready;
      1: return bus.wready;
      2: return bus.bvalid && bus.bready;
      3: return bus.arready;
      default: return bus.rvalid && bus.rready;
    endcase
  endfunction

  // Waits (bounded) until the selected handshake is pending, then steps past its edge.
  task automatic await(input int sel, input string name);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (!sig(sel) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (!sig(sel)) timeout(name);
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [30:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [4:0] id, input int last_at);
    model_write(addr, len, size, burst, id, last_at);
    cap_bresp.delete();
    bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst; bus.awid = id;
    bus.awvalid = 1'b1;
    await(0, "aw_handshake");
    bus.awvalid = 1'b0;
    check("wready_latency", 64'(bus.wready), 64'd1);
    for (int i = 0; i <= last_at; i++) begin
      bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = (i == last_at); bus.wvalid = 1'b1;
      await(1, "w_handshake");
    end
    bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
    check("bvalid_latency", 64'(bus.bvalid), 64'd1);
    await(2, "b_handshake");
  endtask

  task automatic bus_read(input logic [30:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [4:0] id,
                          input int stall_beat, input int stall_cycles);
    model_read(addr, len, size, burst, id);
    cap_rdata.delete(); cap_rresp.delete(); cap_rlast.delete();
    bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst; bus.arid = id;
    bus.arvalid = 1'b1;
    await(3, "ar_handshake");
    bus.arvalid = 1'b0;
    check("rvalid_latency", 64'(bus.rvalid), 64'd1);
    for (int b = 0; b <= int'(len); b++) begin
      if (b == stall_beat) begin
        bus.rready = 1'b0;
        repeat (stall_cycles) @(posedge clk);
        #1;
        bus.rready = 1'b1;
      end
      await(4, "r_handshake");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.awlock = 0; bus.awcache = 0; bus.awprot = 0; bus.awqos = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 1;
    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    bus.arlock = 0; bus.arcache = 0; bus.arprot = 0; bus.arqos = 0;
    bus.rready = 1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 64'(bus.awready), 0);
    check("rst_arready", 64'(bus.arready), 0);
    check("rst_valids", 64'({bus.wready, bus.bvalid, bus.rvalid, bus.rlast}), 0);
    check("rst_ids", 64'({bus.bid, bus.rid}), 0);
    check("rst_resps", 64'({bus.bresp, bus.rresp}), 0);
    check("rst_rdata", bus.rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("awready_before_edge", 64'(bus.awready), 0);
    @(posedge clk);
    #1;
    check("awready_after_edge", 64'(bus.awready), 1);
    check("arready_after_edge", 64'(bus.arready), 1);

    // Single write / read
    wd[0] = 64'hDEAD_BEEF_0123_4567; ws[0] = 8'hFF;
    bus_write(31'h6000_0010, 8'd0, 3'd3, INCR, 5'd3, 0);
    check("single_bresp", 64'(cap_bresp[0]), 64'(OKAY));
    bus_read(31'h6000_0010, 8'd0, 3'd3, INCR, 5'd4, -1, 0);
    check("single_rdata", cap_rdata[0], 64'hDEAD_BEEF_0123_4567);
    check("single_rlast", 64'(cap_rlast[0]), 1);
    check("single_rresp", 64'(cap_rresp[0]), 64'(OKAY));

    // INCR burst of 4 with a 5-cycle rready stall on beat 1
    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
    bus_write(31'h6000_0000, 8'd3, 3'd3, INCR, 5'd5, 3);
    bus_read(31'h6000_0000, 8'd3, 3'd3, INCR, 5'd6, 1, 5);
    for (int i = 0; i < 4; i++) begin
      check("incr_rdata", cap_rdata[i], 64'(i + 1));
      check("incr_rlast", 64'(cap_rlast[i]), 64'(i == 3));
    end

    // FIXED burst with complementary strobes
    wd[0] = 64'h1111_2222_3333_4444; ws[0] = 8'h0F;
    wd[1] = 64'hAAAA_BBBB_CCCC_DDDD; ws[1] = 8'hF0;
    bus_write(31'h6000_0040, 8'd1, 3'd3, FIXED, 5'd7, 1);
    bus_read(31'h6000_0040, 8'd0, 3'd3, INCR, 5'd7, -1, 0);
    check("fixed_merge", cap_rdata[0], 64'hAAAA_BBBB_3333_4444);

    // WRAP bursts are rejected
    wd[0] = 64'h5555_5555_5555_5555; ws[0] = 8'hFF;
    wd[1] = 64'h6666_6666_6666_6666; ws[1] = 8'hFF;
    bus_write(31'h6000_0040, 8'd1, 3'd3, WRAP, 5'd10, 1);
    check("wrap_bresp", 64'(cap_bresp[0]), 64'(SLVERR));
    bus_read(31'h6000_0040, 8'd0, 3'd3, INCR, 5'd11, -1, 0);
    check("wrap_unchanged", cap_rdata[0], 64'hAAAA_BBBB_3333_4444);
    bus_read(31'h6000_0040, 8'd1, 3'd3, WRAP, 5'd12, -1, 0);
    for (int i = 0; i < 2; i++) begin
      check("wrap_rdata", cap_rdata[i], 64'h0);
      check("wrap_rresp", 64'(cap_rresp[i]), 64'(SLVERR));
    end

    // Early wlast on beat 1 of a len-3 write
    wd[0] = 64'h77; ws[0] = 8'hFF; wd[1] = 64'h88; ws[1] = 8'hFF;
    bus_write(31'h6000_0080, 8'd3, 3'd3, INCR, 5'd13, 1);
    check("early_wlast_bresp", 64'(cap_bresp[0]), 64'(SLVERR));

    // Window-edge address with a same-edge read of that word
    wd[0] = 64'h0000_0000_0000_CAFE; ws[0] = 8'hFF;
    model_read(ALIAS, 8'd0, 3'd3, INCR, 5'd9);
    model_write(ALIAS, 8'd0, 3'd3, INCR, 5'd8, 0);
    cap_rdata.delete(); cap_rresp.delete(); cap_rlast.delete(); cap_bresp.delete();
    bus.awaddr = ALIAS; bus.awlen = 0; bus.awsize = 3; bus.awburst = INCR; bus.awid = 5'd8;
    bus.awvalid = 1'b1;
    await(0, "alias_aw");
    bus.awvalid = 1'b0;
    bus.wdata = wd[0]; bus.wstrb = ws[0]; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = ALIAS; bus.arlen = 0; bus.arsize = 3; bus.arburst = INCR; bus.arid = 5'd9;
    bus.arvalid = 1'b1;
    check("collide_readies", 64'({bus.wready, bus.arready}), 64'd3);
    @(posedge clk);
    #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.arvalid = 1'b0;
    check("collide_rvalid", 64'(bus.rvalid), 1);
    check("collide_bvalid", 64'(bus.bvalid), 1);
    await(4, "collide_r");
`ifdef AXI_MMIO_TARGET_DECERR_EN
    check("collide_rdata", cap_rdata[0], 64'h0);
    check("collide_rresp", 64'(cap_rresp[0]), 64'(DECERR));
    check("collide_bresp", 64'(cap_bresp[0]), 64'(DECERR));
    bus_read(BASE, 8'd0, 3'd3, INCR, 5'd14, -1, 0);
    check("alias_word0", cap_rdata[0], 64'd1);
`else
    check("collide_rdata", cap_rdata[0], 64'd1);
    check("collide_rresp", 64'(cap_rresp[0]), 64'(OKAY));
    check("collide_bresp", 64'(cap_bresp[0]), 64'(OKAY));
    bus_read(BASE, 8'd0, 3'd3, INCR, 5'd14, -1, 0);
    check("alias_word0", cap_rdata[0], 64'h0000_0000_0000_CAFE);
`endif

    // Reset in the middle of a read burst
    model_read(31'h6000_0008, 8'd2, 3'd3, INCR, 5'd15);
    bus.araddr = 31'h6000_0008; bus.arlen = 2; bus.arsize = 3; bus.arburst = INCR; bus.arid = 5'd15;
    bus.arvalid = 1'b1;
    await(3, "midrst_ar");
    bus.arvalid = 1'b0;
    await(4, "midrst_r");
    reset = 1'b1;
    #1;
    check("midrst_rvalid", 64'(bus.rvalid), 0);
    check("midrst_arready", 64'(bus.arready), 0);
    exp_r.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus_read(31'h6000_0008, 8'd0, 3'd3, INCR, 5'd16, -1, 0);
    check("midrst_mem_kept", cap_rdata[0], 64'd2);

    repeat (3) @(posedge clk);
    check("r_queue_drained", 64'(exp_r.size()), 0);
    check("b_queue_drained", 64'(exp_b.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_mmio_target.md
# axi_mmio_target

AXI4 slave responder terminating the Rocket MMIO master port (`M_AXI_MMIO_*` of the core wrapper). It is a 64-bit scratch/register window backed by an internal flop array. It accepts FIXED and INCR bursts on independent read and write channels, one outstanding transaction per direction. It is used as a bring-up MMIO target and as the bench model for the core's MMIO path.

## Interface
- `ADDR_WIDTH`, 31: AXI address width; matches the core MMIO port.
- `ID_WIDTH`, 5: AXI ID width.
- `DEPTH`, 512: number of 64-bit words; power of two, 2..4096.
- `BASE_ADDR`, 31'h6000_0000: byte base of the window; aligned to DEPTH*8.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- AW channel:
  - `S_AXI_awvalid`/`awready`: in/out, 1 each.
  - `S_AXI_awid` in ID_WIDTH.
  - `S_AXI_awaddr` in ADDR_WIDTH.
  - `S_AXI_awlen` in 8.
  - `S_AXI_awsize` in 3.
  - `S_AXI_awburst` in 2.
  - `S_AXI_awlock`/`awcache`/`awprot`/`awqos`: in 1/4/3/4; ignored.
- W channel:
  - `S_AXI_wvalid`/`wready`: in/out, 1 each.
  - `S_AXI_wdata` in 64.
  - `S_AXI_wstrb` in 8.
  - `S_AXI_wlast` in 1.
- B channel:
  - `S_AXI_bvalid` out 1.
  - `S_AXI_bready` in 1.
  - `S_AXI_bid` out ID_WIDTH.
  - `S_AXI_bresp` out 2.
- AR channel: same fields as AW, `ar` prefix.
- R channel:
  - `S_AXI_rvalid` out 1.
  - `S_AXI_rready` in 1.
  - `S_AXI_rid` out ID_WIDTH.
  - `S_AXI_rdata` out 64.
  - `S_AXI_rresp` out 2.
  - `S_AXI_rlast` out 1.

## Operation
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: `awready`=1. An AW handshake latches id, addr, len, size and burst, and clears the beat counter.
  - W_DATA: `wready`=1. Each W handshake applies `wstrb` byte enables to word `idx` and advances the address. `wlast` ends the burst.
  - W_RESP: `bvalid`=1 until `bready`.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: `arready`=1. An AR handshake latches the fields and loads the `rdata`/`rresp` registers for beat 0.
  - R_DATA: `rvalid`=1. `rlast` = (beat == len). Each R handshake loads the next beat. The FSM returns to R_IDLE after the last-beat handshake.
- Address arithmetic:
  - Offset = addr - BASE_ADDR, modulo 2^ADDR_WIDTH.
  - idx = offset[3+log2(DEPTH)-1:3].
  - INCR: next addr = (addr & ~((1<<size)-1)) + (1<<size).
  - FIXED: address unchanged.
- Response codes:
  - burst==WRAP or reserved(3), or size>3: SLVERR. Writes are dropped; reads return 0. The burst still runs len+1 beats.
  - Write response: SLVERR if wlast arrives at beat != len, or is absent at beat len. The burst ends only on wlast; beats after len are dropped.
  - Otherwise OKAY; error priority: SLVERR over DECERR.
  - bresp is the worst of any per-beat errors.
- Read and write channels are fully independent and may be active in the same cycle.

## Timing
- Reset values: all ready/valid outputs 0; `bid`/`rid`/`rdata`/`bresp`/`rresp`/`rlast` all 0; both FSMs idle.
- `awready`/`arready` are registered and rise on the first clk edge after reset deasserts.
- Latencies:
  - AW handshake at cycle N -> `wready` at N+1.
  - Last W handshake at M -> `bvalid` at M+1.
  - AR handshake at N -> `rvalid` at N+1.
  - Back-to-back read beats: one per cycle while `rready`=1.
- Read/write collision: `rdata` is a register loaded at the edge that launches the beat, so it holds the array value from before any write committing on that same edge. The write is visible to beats loaded later.
- R and B outputs are stable while valid is high and ready is low.
- Asserting reset mid-burst aborts both FSMs immediately. The array is not reset and keeps its contents.

## Configuration
- `AXI_MMIO_TARGET_DECERR_EN` defined: a beat with offset >= DEPTH*8 gets DECERR. Writes are dropped; reads return 64'h0.
- Undefined: no range check. idx wraps modulo DEPTH; response OKAY.

## Test plan
- Single write/read: AW addr 0x6000_0010, len 0, size 3, wdata 64'hDEAD_BEEF_0123_4567, strb FF -> bresp OKAY at M+1. AR to the same address -> rdata 64'hDEAD_BEEF_0123_4567, rlast=1, rresp OKAY.
- INCR burst, len 3, at 0x6000_0000, data 1,2,3,4 -> reading back gives 1,2,3,4 with rlast only on the 4th beat. Holding `rready` low 5 cycles mid-burst keeps rdata stable.
- FIXED write, len 1, data A then B, strb 0x0F then 0xF0 -> word = {B[63:32], A[31:0]}.
- WRAP burst, len 1 -> bresp SLVERR, array unchanged; a WRAP read returns 2 beats of 0 with SLVERR.
- Early wlast at beat 1 of a len-3 write -> bvalid the next cycle with SLVERR.
- Address 0x6000_0000 + DEPTH*8: with the macro, DECERR and rdata 0; without it, aliases word 0 with OKAY. Concurrently with a read of the same word, the same-edge write is not seen by the read beat.
